// File: rtl/fp_cmp_reduce.sv
// Streaming floating-point max/min reduction: one element per accepted beat, result
// (extreme value, its index, element count, NaN and overflow flags) after the last one.
module fp_cmp_reduce #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23,
    parameter int unsigned IDX_W = 16,
    localparam int unsigned W    = 1 + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [W-1:0]     i_data,
    input  logic             i_last,
    input  logic             i_mode,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [W-1:0]     o_value,
    output logic [IDX_W-1:0] o_index,
    output logic [IDX_W-1:0] o_count,
    output logic             o_nan_err,
    output logic             o_ovf
);

    typedef enum logic [1:0] {StIdle, StAcc, StHold} state_e;

    localparam logic [IDX_W-1:0] CntMax = {IDX_W{1'b1}};
    localparam logic [W-1:0]     QNan   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [W-1:0]     SignBit = {1'b1, {(W-1){1'b0}}};

    function automatic logic is_nan(input logic [W-1:0] x);
        return (x[W-2 -: EXP_W] == {EXP_W{1'b1}}) && (x[MAN_W-1:0] != '0);
    endfunction

    // Order-preserving unsigned key; -0 folds onto +0 so the two compare equal.
    function automatic logic [W-1:0] key_f(input logic [W-1:0] x);
        if (x[W-2:0] == '0) begin
            return SignBit;
        end else if (x[W-1]) begin
            return ~x;
        end else begin
            return x ^ SignBit;
        end
    endfunction

    state_e state_q, state_d;

    logic [W-1:0]     best_q, best_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic             nan_q, nan_d;
    logic             ovf_q, ovf_d;

    logic [W-1:0]     res_value_q, res_value_d;
    logic [IDX_W-1:0] res_index_q, res_index_d;
    logic [IDX_W-1:0] res_count_q, res_count_d;
    logic             res_nan_q, res_nan_d;
    logic             res_ovf_q, res_ovf_d;

    logic accept;
    logic [W-1:0] key_in, key_best;
    logic better;

    assign o_valid = (state_q == StHold);
    assign o_ready = (state_q == StHold) ? i_ready : 1'b1;
    assign accept  = i_valid && o_ready;

    assign key_in   = key_f(i_data);
    assign key_best = key_f(best_q);
    assign better   = mode_q ? (key_in < key_best) : (key_in > key_best);

    always_comb begin
        best_d      = best_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        nan_d       = nan_q;
        ovf_d       = ovf_q;
        res_value_d = res_value_q;
        res_index_d = res_index_q;
        res_count_d = res_count_q;
        res_nan_d   = res_nan_q;
        res_ovf_d   = res_ovf_q;

        if (accept) begin
            // Accepting in IDLE or HOLD always starts a fresh vector.
            if (state_q != StAcc) begin
                best_d = i_data;
                idx_d  = '0;
                cnt_d  = IDX_W'(1);
                mode_d = i_mode;
                nan_d  = is_nan(i_data);
                ovf_d  = 1'b0;
            end else begin
                if (cnt_q == CntMax) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
                if (!nan_q) begin
                    if (is_nan(i_data)) begin
                        nan_d = 1'b1;
                        idx_d = cnt_q;
                    end else if (better) begin
                        best_d = i_data;
                        idx_d  = cnt_q;
                    end
                end
            end

            if (i_last) begin
                res_value_d = nan_d ? QNan : best_d;
                res_index_d = idx_d;
                res_count_d = cnt_d;
                res_nan_d   = nan_d;
                res_ovf_d   = ovf_d;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = i_last ? StHold : StAcc;
                end
            end
            StAcc: begin
                if (accept && i_last) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (accept) begin
                    state_d = i_last ? StHold : StAcc;
                end else if (i_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            best_q      <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            mode_q      <= 1'b0;
            nan_q       <= 1'b0;
            ovf_q       <= 1'b0;
            res_value_q <= '0;
            res_index_q <= '0;
            res_count_q <= '0;
            res_nan_q   <= 1'b0;
            res_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            best_q      <= best_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            nan_q       <= nan_d;
            ovf_q       <= ovf_d;
            res_value_q <= res_value_d;
            res_index_q <= res_index_d;
            res_count_q <= res_count_d;
            res_nan_q   <= res_nan_d;
            res_ovf_q   <= res_ovf_d;
        end
    end

    assign o_value   = res_value_q;
    assign o_index   = res_index_q;
    assign o_count   = res_count_q;
    assign o_nan_err = res_nan_q;
    assign o_ovf     = res_ovf_q;

endmodule

// File: tb/tb_fp_cmp_reduce.sv
// Directed bench for fp_cmp_reduce: a default FP32 instance and a narrow IDX_W=2 instance.
module tb_fp_cmp_reduce;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    // Default instance
    logic        i_valid = 1'b0, i_last = 1'b0, i_mode = 1'b0, i_ready = 1'b0;
    logic [31:0] i_data = '0;
    logic        o_ready, o_valid, o_nan_err, o_ovf;
    logic [31:0] o_value;
    logic [15:0] o_index, o_count;

    // Narrow-index instance
    logic        s_valid = 1'b0, s_last = 1'b0, s_mode = 1'b0, s_iready = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_oready, s_ovalid, s_nan, s_ovf;
    logic [31:0] s_value;
    logic [1:0]  s_index, s_count;

    int total = 0;
    int bad = 0;

    fp_cmp_reduce dut (
        .clk(clk), .rstn(rstn), .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
        .i_last(i_last), .i_mode(i_mode), .o_valid(o_valid), .i_ready(i_ready),
        .o_value(o_value), .o_index(o_index), .o_count(o_count), .o_nan_err(o_nan_err),
        .o_ovf(o_ovf)
    );

    fp_cmp_reduce #(.EXP_W(8), .MAN_W(23), .IDX_W(2)) dut_s (
        .clk(clk), .rstn(rstn), .i_valid(s_valid), .o_ready(s_oready), .i_data(s_data),
        .i_last(s_last), .i_mode(s_mode), .o_valid(s_ovalid), .i_ready(s_iready),
        .o_value(s_value), .o_index(s_index), .o_count(s_count), .o_nan_err(s_nan),
        .o_ovf(s_ovf)
    );

    task automatic send(input logic [31:0] d, input logic last, input logic mode);
        int n;
        i_data = d; i_last = last; i_mode = mode; i_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!o_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!o_ready) begin
            total++; bad++;
            $display("FAIL send_timeout: o_ready=%0b required 1", o_ready);
        end
        @(posedge clk); #1;
        i_valid = 1'b0; i_last = 1'b0;
    endtask

    task automatic send_s(input logic [31:0] d, input logic last);
        int n;
        s_data = d; s_last = last; s_mode = 1'b0; s_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_oready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!s_oready) begin
            total++; bad++;
            $display("FAIL send_s_timeout: o_ready=%0b required 1", s_oready);
        end
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic pop();
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;
    endtask

    task automatic check_res(input string name, input logic [31:0] v, input logic [15:0] idx,
                             input logic [15:0] cnt, input logic nan);
        total++;
        if (o_valid !== 1'b1 || o_value !== v || o_index !== idx || o_count !== cnt ||
            o_nan_err !== nan || o_ovf !== 1'b0) begin
            bad++;
            $display("FAIL %s: got v=%0b val=%h idx=%0d cnt=%0d nan=%0b ovf=%0b want v=1 val=%h idx=%0d cnt=%0d nan=%0b ovf=0",
                     name, o_valid, o_value, o_index, o_count, o_nan_err, o_ovf, v, idx, cnt, nan);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_value !== 32'h0 || o_index !== 16'h0 ||
            o_count !== 16'h0 || o_nan_err !== 1'b0 || o_ovf !== 1'b0) begin
            bad++;
            $display("FAIL reset: v=%0b rdy=%0b val=%h idx=%0d cnt=%0d nan=%0b ovf=%0b want rdy=1 rest 0",
                     o_valid, o_ready, o_value, o_index, o_count, o_nan_err, o_ovf);
        end
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_max();
        send(32'h3F800000, 1'b0, 1'b0);
        send(32'hC0400000, 1'b0, 1'b0);
        total++;
        if (o_valid !== 1'b0) begin
            bad++;
            $display("FAIL max_early_valid: o_valid=%0b required 0", o_valid);
        end
        send(32'h40000000, 1'b1, 1'b0);
        check_res("max", 32'h40000000, 16'd2, 16'd3, 1'b0);
        pop();
        total++;
        if (o_valid !== 1'b0 || o_value !== 32'h40000000 || o_count !== 16'd3) begin
            bad++;
            $display("FAIL max_hold_after_pop: v=%0b val=%h cnt=%0d want v=0 val=40000000 cnt=3",
                     o_valid, o_value, o_count);
        end
    endtask

    task automatic test_min();
        // Later elements carry mode=0; it must be ignored mid-vector.
        send(32'h3F800000, 1'b0, 1'b1);
        send(32'hC0400000, 1'b0, 1'b0);
        send(32'h40000000, 1'b1, 1'b0);
        check_res("min", 32'hC0400000, 16'd1, 16'd3, 1'b0);
        pop();
    endtask

    task automatic test_neg_zero();
        send(32'h80000000, 1'b0, 1'b0);
        send(32'h00000000, 1'b1, 1'b0);
        check_res("neg_zero_tie", 32'h80000000, 16'd0, 16'd2, 1'b0);
        pop();
    endtask

    task automatic test_nan();
        send(32'h3F800000, 1'b0, 1'b0);
        send(32'h7FC00001, 1'b0, 1'b0);
        send(32'h7F800000, 1'b1, 1'b0);
        check_res("nan", 32'h7FC00000, 16'd1, 16'd3, 1'b1);
        pop();
    endtask

    task automatic test_back_to_back();
        send(32'h40000000, 1'b1, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_value !== 32'h40000000 ||
                o_count !== 16'd1) begin
                bad++;
                $display("FAIL backpressure_c%0d: rdy=%0b v=%0b val=%h cnt=%0d want rdy=0 v=1 val=40000000 cnt=1",
                         c, o_ready, o_valid, o_value, o_count);
            end
        end
        @(posedge clk); #1;
        // Result transfer and next-vector first element in the same cycle.
        i_ready = 1'b1;
        i_valid = 1'b1; i_data = 32'hFF800000; i_last = 1'b1; i_mode = 1'b1;
        @(negedge clk);
        total++;
        if (o_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_ready: o_ready=%0b required 1", o_ready);
        end
        @(posedge clk); #1;
        i_valid = 1'b0; i_last = 1'b0; i_ready = 1'b0;
        check_res("b2b_single_neg_inf", 32'hFF800000, 16'd0, 16'd1, 1'b0);
        pop();
        total++;
        if (o_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_drain: o_valid=%0b required 0", o_valid);
        end
    endtask

    task automatic test_reset_mid();
        send(32'h40400000, 1'b0, 1'b0);
        send(32'h40800000, 1'b0, 1'b0);
        #2 rstn = 1'b0;
        #1;
        total++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid: v=%0b rdy=%0b want v=0 rdy=1", o_valid, o_ready);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (o_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_no_result: o_valid=%0b required 0", o_valid);
        end
        send(32'h3F800000, 1'b1, 1'b0);
        check_res("after_reset_fresh", 32'h3F800000, 16'd0, 16'd1, 1'b0);
        pop();
    endtask

    task automatic test_ovf();
        send_s(32'h40000000, 1'b0);
        send_s(32'h3F800000, 1'b0);
        send_s(32'h3F800000, 1'b0);
        send_s(32'h3F800000, 1'b0);
        send_s(32'h40400000, 1'b1);
        total++;
        if (s_ovalid !== 1'b1 || s_value !== 32'h40400000 || s_index !== 2'd3 ||
            s_count !== 2'd3 || s_ovf !== 1'b1 || s_nan !== 1'b0) begin
            bad++;
            $display("FAIL ovf: v=%0b val=%h idx=%0d cnt=%0d ovf=%0b nan=%0b want v=1 val=40400000 idx=3 cnt=3 ovf=1 nan=0",
                     s_ovalid, s_value, s_index, s_count, s_ovf, s_nan);
        end
        s_iready = 1'b1;
        @(posedge clk); #1;
        s_iready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_max();
        test_min();
        test_neg_zero();
        test_nan();
        test_back_to_back();
        test_reset_mid();
        test_ovf();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
